ram_port_arbiter: RTL and testbench

//  Shares one Single_Port_RAM between two requesters (r0, r1) with round-robin arbitration.

---
 rtl/ram_arb_pkg.sv | 17 +
 rtl/rr_arb2.sv | 28 ++
 rtl/ram_port_arbiter.sv | 156 +++++++++++++++
 tb/tb_ram_port_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-requester RAM port arbiter: FSM states,
// RAM operation encoding and requester identifiers.
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR      = 2'd1,
        RD_WAIT = 2'd2
    } arb_state_t;

    localparam logic WR_OP = 1'b1;
    localparam logic RD_OP = 1'b0;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin picker; the pointer register lives in the
// parent so this block only decides who wins and where the pointer goes next.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_grant,
    output logic       o_next_ptr
);

    // The pointer only matters on a tie; any grant hands priority to the loser side.
    always_comb begin
        o_grant    = 2'b00;
        o_next_ptr = i_ptr;
        if (i_req == 2'b11) begin
            o_grant = (i_ptr == REQ1) ? 2'b10 : 2'b01;
        end else begin
            o_grant = i_req;
        end
        if (o_grant[0]) begin
            o_next_ptr = REQ1;
        end else if (o_grant[1]) begin
            o_next_ptr = REQ0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port RAM between two requesters with round-robin
// arbitration; read data is steered back to the requester that issued the read.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int addr_width = 3,
    parameter int data_width = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic                  i_r0_req,
    input  logic                  i_r0_wr_rd,
    input  logic [addr_width-1:0] i_r0_addr,
    input  logic [data_width-1:0] i_r0_wdata,
    output logic                  o_r0_gnt,
    output logic [data_width-1:0] o_r0_rdata,
    output logic                  o_r0_rvalid,
    output logic                  o_r0_err,

    input  logic                  i_r1_req,
    input  logic                  i_r1_wr_rd,
    input  logic [addr_width-1:0] i_r1_addr,
    input  logic [data_width-1:0] i_r1_wdata,
    output logic                  o_r1_gnt,
    output logic [data_width-1:0] o_r1_rdata,
    output logic                  o_r1_rvalid,
    output logic                  o_r1_err,

    output logic                  o_ram_en,
    output logic                  o_ram_wr_rd,
    output logic [addr_width-1:0] o_ram_addr,
    output logic [data_width-1:0] o_ram_din,
    input  logic [data_width-1:0] i_ram_dout,
    input  logic                  i_ram_out_en,

    output logic                  o_busy
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    arb_state_t                       r_state;
    logic                             r_ptr;
    logic                             r_owner;
    logic [CNT_W-1:0]                 r_cnt;
    logic [1:0]                       r_gnt;
    logic [1:0]                       r_rvalid;
    logic [1:0]                       r_err;
    logic [1:0][data_width-1:0]       r_rdata;
    logic                             r_ram_en;
    logic                             r_ram_wr_rd;
    logic [addr_width-1:0]            r_ram_addr;
    logic [data_width-1:0]            r_ram_din;

    logic [1:0]                       w_req;
    logic [1:0]                       w_grant;
    logic                             w_next_ptr;
    logic                             w_winner;
    logic                             w_wr_rd;
    logic [addr_width-1:0]            w_addr;
    logic [data_width-1:0]            w_wdata;

    assign w_req = {i_r1_req, i_r0_req};

    rr_arb2 u_rr_arb2 (
        .i_req      (w_req),
        .i_ptr      (r_ptr),
        .o_grant    (w_grant),
        .o_next_ptr (w_next_ptr)
    );

    assign w_winner = w_grant[1] ? REQ1 : REQ0;
    assign w_wr_rd  = (w_winner == REQ1) ? i_r1_wr_rd : i_r0_wr_rd;
    assign w_addr   = (w_winner == REQ1) ? i_r1_addr  : i_r0_addr;
    assign w_wdata  = (w_winner == REQ1) ? i_r1_wdata : i_r0_wdata;

    // Single FSM: pulses default low each cycle, so gnt/rvalid/err are one-cycle strobes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_ptr       <= REQ0;
            r_owner     <= REQ0;
            r_cnt       <= '0;
            r_gnt       <= '0;
            r_rvalid    <= '0;
            r_err       <= '0;
            r_rdata     <= '0;
            r_ram_en    <= 1'b0;
            r_ram_wr_rd <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_din   <= '0;
        end else begin
            r_gnt    <= '0;
            r_rvalid <= '0;
            r_err    <= '0;
            case (r_state)
                IDLE: begin
                    if (|w_grant) begin
                        r_ptr       <= w_next_ptr;
                        r_gnt       <= w_grant;
                        r_ram_en    <= 1'b1;
                        r_ram_wr_rd <= w_wr_rd;
                        r_ram_addr  <= w_addr;
                        if (w_wr_rd == WR_OP) begin
                            r_ram_din <= w_wdata;
                            r_state   <= WR;
                        end else begin
                            r_owner <= w_winner;
                            r_cnt   <= '0;
                            r_state <= RD_WAIT;
                        end
                    end
                end
                WR: begin
                    r_ram_en <= 1'b0;
                    r_state  <= IDLE;
                end
                RD_WAIT: begin
                    // Returned data takes precedence over a timeout landing on the same edge.
                    if (i_ram_out_en) begin
                        r_rdata[r_owner]  <= i_ram_dout;
                        r_rvalid[r_owner] <= 1'b1;
                        r_ram_en          <= 1'b0;
                        r_state           <= IDLE;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_err[r_owner] <= 1'b1;
                        r_ram_en       <= 1'b0;
                        r_state        <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_ram_en <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign o_r0_gnt    = r_gnt[0];
    assign o_r1_gnt    = r_gnt[1];
    assign o_r0_rvalid = r_rvalid[0];
    assign o_r1_rvalid = r_rvalid[1];
    assign o_r0_err    = r_err[0];
    assign o_r1_err    = r_err[1];
    assign o_r0_rdata  = r_rdata[0];
    assign o_r1_rdata  = r_rdata[1];
    assign o_ram_en    = r_ram_en;
    assign o_ram_wr_rd = r_ram_wr_rd;
    assign o_ram_addr  = r_ram_addr;
    assign o_ram_din   = r_ram_din;
    assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: a behavioural RAM plus a
// transaction-level model (priority pointer, scoreboard memory, expected timing).
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int AW = 3;
    localparam int DW = 8;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          r0Req = 1'b0, r0WrRd = 1'b0, r1Req = 1'b0, r1WrRd = 1'b0;
    logic [AW-1:0] r0Addr = '0, r1Addr = '0;
    logic [DW-1:0] r0Wdata = '0, r1Wdata = '0;
    logic          r0Gnt, r0Rvalid, r0Err, r1Gnt, r1Rvalid, r1Err;
    logic [DW-1:0] r0Rdata, r1Rdata;
    logic          ramEn, ramWrRd, busy;
    logic [AW-1:0] ramAddr;
    logic [DW-1:0] ramDin;
    logic [DW-1:0] ramDout = '0;
    logic          ramOutEn = 1'b0;
    logic [DW-1:0] ramArray [0:7];
    logic          ramMute = 1'b0;
    logic [35:0]   allOuts;

    int            testsRun = 0;
    int            failCount = 0;
    logic [DW-1:0] sbMem [0:7];
    int            modelPtr = 0;
    logic [DW-1:0] lastRdata [2];

    ram_port_arbiter #(.addr_width(AW), .data_width(DW), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_r0_req(r0Req), .i_r0_wr_rd(r0WrRd), .i_r0_addr(r0Addr), .i_r0_wdata(r0Wdata),
        .o_r0_gnt(r0Gnt), .o_r0_rdata(r0Rdata), .o_r0_rvalid(r0Rvalid), .o_r0_err(r0Err),
        .i_r1_req(r1Req), .i_r1_wr_rd(r1WrRd), .i_r1_addr(r1Addr), .i_r1_wdata(r1Wdata),
        .o_r1_gnt(r1Gnt), .o_r1_rdata(r1Rdata), .o_r1_rvalid(r1Rvalid), .o_r1_err(r1Err),
        .o_ram_en(ramEn), .o_ram_wr_rd(ramWrRd), .o_ram_addr(ramAddr), .o_ram_din(ramDin),
        .i_ram_dout(ramDout), .i_ram_out_en(ramOutEn), .o_busy(busy)
    );

    assign allOuts = {r0Gnt, r0Rvalid, r0Err, r0Rdata, r1Gnt, r1Rvalid, r1Err, r1Rdata,
                      ramEn, ramWrRd, ramAddr, ramDin, busy};

    always #5 clk = ~clk;

    // Behavioural single-port RAM: read data and out_en appear one edge after a read command.
    always @(posedge clk) begin
        ramOutEn <= ramEn && !ramWrRd && !ramMute;
        if (ramEn && ramWrRd) ramArray[ramAddr] <= ramDin;
        if (ramEn && !ramWrRd) ramDout <= ramArray[ramAddr];
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Issues up to one transaction per requester and follows them to completion.
    task automatic applyStimulus(input bit v0, input bit op0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input bit v1, input bit op1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                                 input bit expectErr);
        bit            want [2];
        bit            got [2];
        bit            fin [2];
        bit            op [2];
        logic [AW-1:0] ad [2];
        logic [DW-1:0] wd [2];
        bit            gntV [2];
        bit            rvV [2];
        bit            erV [2];
        logic [DW-1:0] rdV [2];
        int            nextGntCyc = 0;
        int            readOwner = -1;
        int            readGntCyc = 0;
        int            expWin;
        bit            finished = 1'b0;
        want = '{v0, v1}; op = '{op0, op1}; ad = '{a0, a1}; wd = '{d0, d1};
        got = '{1'b0, 1'b0}; fin = '{1'b0, 1'b0};
        @(negedge clk);
        r0Req = v0; r0WrRd = op0; r0Addr = a0; r0Wdata = d0;
        r1Req = v1; r1WrRd = op1; r1Addr = a1; r1Wdata = d1;
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            @(posedge clk); #1;
            gntV = '{r0Gnt, r1Gnt}; rvV = '{r0Rvalid, r1Rvalid};
            erV = '{r0Err, r1Err}; rdV = '{r0Rdata, r1Rdata};
            if (gntV[0] || gntV[1]) checkOutput("gnt_onehot", 64'(gntV[0] & gntV[1]), 64'd0);
            for (int k = 0; k < 2; k++) begin
                if (gntV[k]) begin
                    expWin = (want[0] && !got[0] && want[1] && !got[1]) ? modelPtr
                           : ((want[0] && !got[0]) ? 0 : 1);
                    checkOutput("gnt_pending", 64'(want[k] && !got[k]), 64'd1);
                    checkOutput("gnt_winner", 64'(k), 64'(expWin));
                    checkOutput("gnt_cycle", 64'(cyc), 64'(nextGntCyc));
                    checkOutput("ram_cmd", 64'({busy, ramEn, ramWrRd, ramAddr}), 64'({1'b1, 1'b1, op[k], ad[k]}));
                    if (op[k]) checkOutput("ram_din", 64'(ramDin), 64'(wd[k]));
                    got[k] = 1'b1;
                    modelPtr = 1 - k;
                    if (k == 0) r0Req = 1'b0; else r1Req = 1'b0;
                    if (op[k]) begin
                        sbMem[ad[k]] = wd[k];
                        fin[k] = 1'b1;
                        nextGntCyc = cyc + 2;
                    end else begin
                        readOwner = k;
                        readGntCyc = cyc;
                    end
                end
                if (rvV[k]) begin
                    checkOutput("rvalid_owner", 64'(k), 64'(readOwner));
                    checkOutput("rvalid_cycle", 64'(cyc), 64'(readGntCyc + 2));
                    checkOutput("rdata", 64'(rdV[k]), 64'(sbMem[ad[k]]));
                    checkOutput("rdata_other_hold", 64'(rdV[1-k]), 64'(lastRdata[1-k]));
                    checkOutput("rvalid_not_err", 64'(expectErr), 64'd0);
                    lastRdata[k] = rdV[k];
                    fin[k] = 1'b1;
                    readOwner = -1;
                    nextGntCyc = cyc + 1;
                end
                if (erV[k]) begin
                    checkOutput("err_owner", 64'(k), 64'(readOwner));
                    checkOutput("err_cycle", 64'(cyc), 64'(readGntCyc + TO));
                    checkOutput("err_rdata_hold", 64'(rdV[k]), 64'(lastRdata[k]));
                    checkOutput("err_expected", 64'(expectErr), 64'd1);
                    fin[k] = 1'b1;
                    readOwner = -1;
                    nextGntCyc = cyc + 1;
                end
            end
            finished = (!want[0] || fin[0]) && (!want[1] || fin[1]) && !busy;
        end
        if (!finished) checkOutput("txn_complete", 64'd0, 64'd1);
        r0Req = 1'b0; r1Req = 1'b0;
    endtask

    initial begin
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [AW-1:0] wa [10];
        bit            spurious;
        lastRdata = '{8'h00, 8'h00};

        // Reset state
        repeat (2) @(posedge clk);
        #1 checkOutput("reset_outputs", 64'(allOuts), 64'd0);
        @(negedge clk) rst = 1'b0;

        // Tie right after reset goes to r0, then r1; a lone r0 grant hands the next tie to r1
        applyStimulus(1, WR_OP, 3'd5, 8'h11, 1, WR_OP, 3'd6, 8'h22, 0);
        applyStimulus(1, WR_OP, 3'd0, 8'h33, 0, RD_OP, 3'd0, 8'h00, 0);
        applyStimulus(1, WR_OP, 3'd1, 8'h44, 1, WR_OP, 3'd2, 8'h55, 0);

        // r0 write then read-back of the same address
        applyStimulus(1, WR_OP, 3'd3, 8'hA5, 0, RD_OP, 3'd0, 8'h00, 0);
        applyStimulus(1, RD_OP, 3'd3, 8'h00, 0, RD_OP, 3'd0, 8'h00, 0);

        // r1 read wins while r0 holds a write request
        applyStimulus(1, WR_OP, 3'd7, 8'h77, 1, RD_OP, 3'd5, 8'h00, 0);

        // Read timeout
        ramMute = 1'b1;
        applyStimulus(1, RD_OP, 3'd3, 8'h00, 0, RD_OP, 3'd0, 8'h00, 1);
        #1 checkOutput("timeout_busy_clear", 64'(busy), 64'd0);

        // Reset while waiting for read data
        @(negedge clk);
        r0Req = 1'b1; r0WrRd = RD_OP; r0Addr = 3'd3;
        @(posedge clk); #1;
        checkOutput("rst_case_gnt", 64'(r0Gnt), 64'd1);
        r0Req = 1'b0;
        repeat (3) @(posedge clk);
        #1 checkOutput("rst_case_busy", 64'(busy), 64'd1);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_mid_outputs", 64'(allOuts), 64'd0);
        @(negedge clk);
        rst = 1'b0; ramMute = 1'b0; modelPtr = 0;
        lastRdata = '{8'h00, 8'h00};
        spurious = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (r0Rvalid || r0Err || r1Rvalid || r1Err || busy) spurious = 1'b1;
        end
        checkOutput("rst_no_late_events", 64'(spurious), 64'd0);
        applyStimulus(0, RD_OP, 3'd0, 8'h00, 1, RD_OP, 3'd5, 8'h00, 0);

        // Prefill every address so later random reads are defined
        for (int i = 0; i < 8; i++) begin
            a = AW'(i);
            d = 8'($urandom);
            if (i % 2 == 0) applyStimulus(1, WR_OP, a, d, 0, RD_OP, 3'd0, 8'h00, 0);
            else            applyStimulus(0, RD_OP, 3'd0, 8'h00, 1, WR_OP, a, d, 0);
        end

        // Random writes alternating requesters, then read-back by random requesters
        for (int i = 0; i < 10; i++) begin
            a = AW'($urandom_range(7));
            d = 8'($urandom);
            wa[i] = a;
            if (i % 2 == 0) applyStimulus(1, WR_OP, a, d, 0, RD_OP, 3'd0, 8'h00, 0);
            else            applyStimulus(0, RD_OP, 3'd0, 8'h00, 1, WR_OP, a, d, 0);
        end
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(1) == 0) applyStimulus(1, RD_OP, wa[i], 8'h00, 0, RD_OP, 3'd0, 8'h00, 0);
            else                        applyStimulus(0, RD_OP, 3'd0, 8'h00, 1, RD_OP, wa[i], 8'h00, 0);
        end

        // Random contention with mixed operations
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1, 1'($urandom_range(1)), AW'($urandom_range(7)), 8'($urandom),
                          1, 1'($urandom_range(1)), AW'($urandom_range(7)), 8'($urandom), 0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
